apb_rx: RTL and testbench

//  UART receive stage, mirror of the APB TX path: deserialises rx_in into 8- or 10-bit words.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/apb_rx_sampler.sv | 60 ++++++
 rtl/apb_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_apb_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and its matching TX build):
// receiver FSM state encoding, minimum baud divisor, data-width constants
// and the even-parity check helper.
// Optional feature macro: UART_PARITY_EN (parity helper used only when set).
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int BAUD_MIN = 4;
    localparam int DATA_W8  = 8;
    localparam int DATA_W10 = 10;

    // 1 when data plus the received even-parity bit has odd weight.
    // Unused data bits must be zero (mode=0 frames leave bits 9:8 clear).
    function automatic logic even_parity_err(input logic [DATA_W10-1:0] data,
                                             input logic                par_bit);
        return (^data) ^ par_bit;
    endfunction

endpackage

// File: rtl/apb_rx_sampler.sv
// ---------------------------------------------------------------------------
// apb_rx_sampler
// Front end of the UART receiver: metastability synchroniser on rx_in,
// falling-edge detector and the bit-period down-counter.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rx_in         asynchronous serial line (idle high)
//   cnt_load      reload the counter with cnt_load_val this cycle
//   cnt_load_val  reload value
//   rx_s          synchronised line
//   fall          synchronised 1->0 transition seen this cycle
//   tick          counter at terminal count (sample point)
// ---------------------------------------------------------------------------
module apb_rx_sampler #(
    parameter int BAUD_W      = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              cnt_load,
    input  logic [BAUD_W-1:0] cnt_load_val,
    output logic              rx_s,
    output logic              fall,
    output logic              tick
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [BAUD_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
        prev_d = sync_q[SYNC_STAGES-1];
        cnt_d  = cnt_q;
        if (cnt_load) begin
            cnt_d = cnt_load_val;
        end else if (cnt_q != '0) begin
            // parks at zero instead of wrapping
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~rx_s;
    assign tick = (cnt_q == '0);

endmodule

// File: rtl/apb_rx.sv
// ---------------------------------------------------------------------------
// apb_rx
// UART receive stage: deserialises rx_in into 8-bit (mode=0) or 10-bit
// (mode=1) words, LSB first, into a single-entry holding register with a
// valid/ready handshake and error flags.
// Optional feature macro: UART_PARITY_EN (even parity bit after data).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sel        enables start detection
//   mode       0 = 8 data bits, 1 = 10 data bits (latched at start)
//   baud       clk cycles per bit, clamped to >= 4 (latched at start)
//   rx_in      serial line
//   rx_ready   consumer accepts dout
//   clr_err    clears overrun
//   rx_valid, dout, frame_err, par_err   holding register contents
//   overrun    sticky: frame dropped while holding register full
//   busy       receiver not idle
//
// state     | meaning
// ST_IDLE   | waiting for falling edge on synchronised line
// ST_START  | counting to middle of start bit, reject glitches
// ST_DATA   | sampling data bits LSB first
// ST_PARITY | sampling parity bit (UART_PARITY_EN only)
// ST_STOP   | sampling stop bit, committing the word
// ---------------------------------------------------------------------------
module apb_rx
    import uart_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int BAUD_W      = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              mode,
    input  logic [BAUD_W-1:0] baud,
    input  logic              rx_in,
    input  logic              rx_ready,
    input  logic              clr_err,
    output logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              frame_err,
    output logic              par_err,
    output logic              overrun,
    output logic              busy
);

    rx_state_t         state_q, state_d;
    logic              mode_q, mode_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ferr_q, ferr_d;
    logic              perr_q, perr_d;
    logic              ovr_q, ovr_d;
`ifdef UART_PARITY_EN
    logic              par_bit_q, par_bit_d;
`endif

    logic              rx_s, fall, tick;
    logic              cnt_load;
    logic [BAUD_W-1:0] cnt_load_val;
    logic              commit;
    logic [BAUD_W-1:0] baud_clamped;
    logic [3:0]        last_bit;

    apb_rx_sampler #(
        .BAUD_W      (BAUD_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .rx_s         (rx_s),
        .fall         (fall),
        .tick         (tick)
    );

    assign baud_clamped = (baud < BAUD_W'(BAUD_MIN)) ? BAUD_W'(BAUD_MIN) : baud;
    assign last_bit     = mode_q ? 4'(DATA_W10 - 1) : 4'(DATA_W8 - 1);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sel && fall) state_d = ST_START;
            ST_START: if (tick) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (tick && bit_q == last_bit) begin
`ifdef UART_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: if (tick) state_d = ST_STOP;
`endif
            ST_STOP:  if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // outputs: counter control, frame datapath, commit
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = baud_q - 1'b1;
        mode_d       = mode_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        commit       = 1'b0;
`ifdef UART_PARITY_EN
        par_bit_d    = par_bit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel && fall) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = baud_clamped >> 1;
                    mode_d       = mode;
                    baud_d       = baud_clamped;
                    bit_d        = '0;
                    shreg_d      = '0;
                end
            end
            ST_START: begin
                if (tick && !rx_s) cnt_load = 1'b1;
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d[bit_q] = rx_s;
                    bit_d          = bit_q + 4'd1;
                    cnt_load       = 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    par_bit_d = rx_s;
                    cnt_load  = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tick) commit = 1'b1;
            end
            default: ;
        endcase
    end

    // holding register and flags
    always_comb begin
        valid_d = valid_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        if (valid_q && rx_ready) valid_d = 1'b0;
        if (commit) begin
            if (!valid_q || rx_ready) begin
                valid_d = 1'b1;
                dout_d  = shreg_q;
                ferr_d  = ~rx_s;
`ifdef UART_PARITY_EN
                perr_d  = even_parity_err(DATA_W10'(shreg_q), par_bit_q);
`else
                perr_d  = 1'b0;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end
        // a new overrun wins over a coincident clear
        if (clr_err && !(commit && valid_q && !rx_ready)) ovr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= 1'b0;
            baud_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            valid_q   <= 1'b0;
            dout_q    <= '0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_PARITY_EN
            par_bit_q <= 1'b0;
`endif
        end else begin
            mode_q    <= mode_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            valid_q   <= valid_d;
            dout_q    <= dout_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
`ifdef UART_PARITY_EN
            par_bit_q <= par_bit_d;
`endif
        end
    end

    assign rx_valid  = valid_q;
    assign dout      = dout_q;
    assign frame_err = ferr_q;
    assign par_err   = perr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_rx.sv
// ---------------------------------------------------------------------------
// tb_apb_rx
// Self-checking bench for apb_rx. Frames are serialised by the bench; the
// expected word/flags for every frame that should be delivered are queued
// when the frame is sent and a monitor compares them on each handshake.
// Honours UART_PARITY_EN to match the DUT build.
// ---------------------------------------------------------------------------
module tb_apb_rx;

    localparam int DATA_W = 10;
    localparam int BAUD_W = 20;

    logic              clk = 1'b0;
    logic              rst, sel, mode, rx_in, rx_ready, clr_err;
    logic [BAUD_W-1:0] baud;
    logic              rx_valid, frame_err, par_err, overrun, busy;
    logic [DATA_W-1:0] dout;

    apb_rx #(.DATA_W(DATA_W), .BAUD_W(BAUD_W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .mode      (mode),
        .baud      (baud),
        .rx_in     (rx_in),
        .rx_ready  (rx_ready),
        .clr_err   (clr_err),
        .rx_valid  (rx_valid),
        .dout      (dout),
        .frame_err (frame_err),
        .par_err   (par_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got dout %0h want none", dout);
            end else begin
                mon_e = sb.pop_front();
                check("dout",      32'(dout),      32'(mon_e.d));
                check("frame_err", 32'(frame_err), 32'(mon_e.fe));
                check("par_err",   32'(par_err),   32'(mon_e.pe));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int bit_period();
        return (baud < 4) ? 4 : int'(baud);
    endfunction

    // Serialise one frame. Expected result is queued only when push=1.
    task automatic send_frame(input logic [9:0] data, input logic md, input logic stop_b,
                              input logic par_flip, input logic push,
                              input logic flip_mode, input logic drop_sel);
        int         p  = bit_period();
        int         n  = md ? 10 : 8;
        logic [9:0] dm = md ? data : {2'b00, data[7:0]};
        logic       pbit = (^dm) ^ par_flip;
        exp_t       e;
        mode = md;
        if (push) begin
            e.d  = dm;
            e.fe = ~stop_b;
`ifdef UART_PARITY_EN
            e.pe = (^dm) ^ pbit;
`else
            e.pe = 1'b0;
`endif
            sb.push_back(e);
        end
        rx_in = 1'b0;
        cyc(p);
        if (flip_mode) mode = ~md;
        if (drop_sel)  sel  = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_in = dm[i];
            cyc(p);
        end
`ifdef UART_PARITY_EN
        rx_in = pbit;
        cyc(p);
`endif
        rx_in = stop_b;
        cyc(p);
        rx_in = 1'b1;
        cyc(2 * p);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 400) begin
            cyc(1);
            k++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
        check({tag, "_dout"},      32'(dout),      32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_par_err"},   32'(par_err),   32'd0);
        check({tag, "_overrun"},   32'(overrun),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        int         busy_cnt;
        logic [9:0] rd;
        rst = 1'b1; sel = 1'b1; mode = 1'b0; baud = 20'd16;
        rx_in = 1'b1; rx_ready = 1'b1; clr_err = 1'b0;
        cyc(3);
        check_all_zero("reset");
        cyc(1);
        rst = 1'b0;
        cyc(4);

        // basic 8-bit frame
        send_frame(10'h0A5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("drain_a5");
        @(negedge clk);
        check("idle_after_frame", 32'(busy), 32'd0);

        // 10-bit frame, mode pin toggled mid-frame
        send_frame(10'h2C3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_2c3");

        // start-bit glitch
        mode = 1'b0;
        rx_in = 1'b0;
        cyc(5);
        rx_in = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("glitch_busy_in_range", 32'(busy_cnt >= 6 && busy_cnt <= 12), 32'd1);
        check("glitch_no_valid", 32'(rx_valid), 32'd0);
        cyc(1);

        // framing error, then a good frame clears it
        send_frame(10'h03C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("drain_3c");
        send_frame(10'h05A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("drain_after_ferr");

        // overrun: second frame dropped while holding register full
        rx_ready = 1'b0;
        send_frame(10'h011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(10'h022, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_dout",  32'(dout),     32'h011);
        check("ovr_flag",  32'(overrun),  32'd1);
        cyc(1);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        @(negedge clk);
        check("ovr_cleared", 32'(overrun), 32'd0);
        cyc(1);
        rx_ready = 1'b1;
        wait_drain("drain_ovr");

        // sel low: no frame detected
        sel = 1'b0;
        send_frame(10'h033, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("sel_off_no_valid", 32'(rx_valid), 32'd0);
        cyc(1);
        sel = 1'b1;

        // sel dropped mid-frame: frame still completes
        send_frame(10'h0F0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain("drain_sel_drop");
        sel = 1'b1;

        // reset in the middle of the data bits
        rx_in = 1'b0; cyc(16);
        rx_in = 1'b1; cyc(16);
        rx_in = 1'b0; cyc(8);
        rx_in = 1'b1;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_all_zero("mid_rst");
        cyc(64);
        send_frame(10'h05A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("drain_after_rst");

`ifdef UART_PARITY_EN
        // parity bit 0 on 0x07 is wrong, parity bit 1 is right
        send_frame(10'h007, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain("drain_par_bad");
        send_frame(10'h007, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("drain_par_good");
`endif

        // randomized frames, baud including clamped values
        for (int i = 0; i < 24; i++) begin
            baud = 20'($urandom_range(0, 24));
            rd   = 10'($urandom);
            send_frame(rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                       1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
            wait_drain("drain_rand");
        end

        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
